ifetch_wishbone: RTL and testbench
==================================

Name: ifetch_wishbone

Overview:
Instruction-fetch master sitting directly upstream of the Wishbone program ROM. It holds the PC, issues pipelined single-word Wishbone reads (STB every cycle, ACK one cycle later) and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and discard the in-flight response.

Parameters:
ADDRESS_WIDTH, 8, ROM word-address width driven on ADR_O
DATA_WIDTH, 32, instruction width
PC_WIDTH, 32, byte-address PC width
RESET_PC, 32'h0000_0000, byte PC fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset; synchronous, active-high
STB_O  out  1  Wishbone read strobe to ROM
WE_O  out  1  always 0
ADR_O  out  ADDRESS_WIDTH  word address = fetch_pc[ADDRESS_WIDTH+1:2]
DAT_I  in  DATA_WIDTH  ROM read data, valid with ACK_I
ACK_I  in  1  ROM acknowledge, one cycle after STB_O
REDIRECT_I  in  1  flush and restart at REDIRECT_PC_I
REDIRECT_PC_I  in  PC_WIDTH  new byte PC
INSTR_O  out  DATA_WIDTH  instruction at FIFO head
PC_O  out  PC_WIDTH  byte PC of INSTR_O
VALID_O  out  1  FIFO non-empty (and not redirecting)
READY_I  in  1  decode accepts head when VALID_O&READY_I

Behaviour:
- Reset (RST_I=1 at posedge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, state=IDLE; STB_O=0, VALID_O=0, INSTR_O=0, PC_O=0, FAULT_O=0 (if present). Reset mid-stream drops any ACK arriving the following cycle.
- FSM: IDLE -> RUN unconditionally one cycle after reset release. RUN -> FLUSH on REDIRECT_I while outstanding=1 (request issued in the previous cycle). RUN -> RUN on REDIRECT_I with outstanding=0. FLUSH -> RUN after one cycle; the ACK arriving in FLUSH is discarded.
- Issue rule (RUN, no REDIRECT_I): STB_O=1 when count + outstanding + (pop ? -1 : 0) < FIFO_DEPTH. On issue: fetch_pc += 4, outstanding=1 for the next cycle. STB_O is combinational from registered state and the current pop.
- Response: ACK_I in RUN pushes {pc_of_request, DAT_I} into the FIFO. ACK_I with no outstanding request is ignored.
- Throughput: 1 instr/cycle sustained with READY_I=1. First VALID_O is 3 cycles after reset release: cycle 1 IDLE, cycle 2 issue, cycle 3 ACK/push, cycle 4 VALID_O.
- Redirect: in the REDIRECT_I cycle, VALID_O=0 and STB_O=0. FIFO is cleared at the next edge; fetch_pc=REDIRECT_PC_I with bits[1:0] cleared. First new issue is the following cycle. REDIRECT_I has priority over push, pop and issue.
- Simultaneous push and pop: count unchanged. Push into a full FIFO cannot occur by the issue rule; assertion in the bench.
- PC wrap: fetch_pc wraps modulo 2^PC_WIDTH. ADR_O wraps modulo 2^ADDRESS_WIDTH.

Optional Feature:
Macro IFETCH_MISALIGN_TRAP_EN.
- Defined: adds output FAULT_O (1 bit). A redirect with REDIRECT_PC_I[1:0]!=0 sets FAULT_O=1 and PC_O=REDIRECT_PC_I; fetching stops with STB_O=0 and VALID_O=0 until the next aligned redirect, which clears FAULT_O.
- Undefined: no FAULT_O port; low two bits are silently forced to 0.

Decomposition:
- Package ifetch_pkg: state enum {IDLE, RUN, FLUSH}, PC_INCR=4, default RESET_PC.
- Sub-module ifetch_fifo: synchronous FIFO of {PC, instruction}, FIFO_DEPTH entries. Provides push, pop, clear (priority over push/pop), count, empty and full.

Test Plan:
- Reset, ROM holds word i = 32'h1000_0000+i, READY_I=1 -> VALID_O first at cycle 4; PC_O 0,4,8,... with INSTR_O 32'h1000_0000,32'h1000_0001,... one per cycle.
- READY_I=0 for 10 cycles -> exactly 2 entries buffered, STB_O=0 afterwards. Releasing READY_I gives gap-free, in-order delivery with no duplicate or lost PC.
- REDIRECT_I with REDIRECT_PC_I=32'h40 while a request is outstanding -> stale ACK dropped. Next PC_O=32'h40 with INSTR_O=word 16, and no old PC appears after the redirect.
- Redirect on the same cycle as pop and ACK -> redirect wins; FIFO empty next cycle and count never exceeds 2.
- ADDRESS_WIDTH=8, fetch runs past PC 32'h3FC -> ADR_O wraps 255->0 while PC_O continues at 32'h400.
- With IFETCH_MISALIGN_TRAP_EN: redirect to 32'h42 -> FAULT_O=1, STB_O=0. Redirect to 32'h80 -> FAULT_O=0 and fetch resumes at 32'h80.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch master: FSM encodings, PC step,
// default reset PC and a small alignment helper.
package ifetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding {PC, instruction} pairs; clear overrides push/pop.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [WIDTH-1:0]          data_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);

endmodule

// File: rtl/ifetch_wishbone.sv
// Pipelined Wishbone instruction-fetch master with a small instruction buffer.
// Optional misaligned-redirect trap (FAULT_O) enabled by IFETCH_MISALIGN_TRAP_EN.
module ifetch_wishbone
  import ifetch_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC      = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH    = 2
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  output logic                     STB_O,
  output logic                     WE_O,
  output logic [ADDRESS_WIDTH-1:0] ADR_O,
  input  logic [DATA_WIDTH-1:0]    DAT_I,
  input  logic                     ACK_I,
  input  logic                     REDIRECT_I,
  input  logic [PC_WIDTH-1:0]      REDIRECT_PC_I,
  output logic [DATA_WIDTH-1:0]    INSTR_O,
  output logic [PC_WIDTH-1:0]      PC_O,
  output logic                     VALID_O,
  input  logic                     READY_I
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic                     FAULT_O
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INCR);

  logic [1:0]                   state_q, state_d;
  logic [PC_WIDTH-1:0]          fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]          req_pc_q, req_pc_d;
  logic                         outstanding_q, outstanding_d;
  logic                         fault_s;
  logic                         issue_s, push_s, pop_s;
  logic [CW-1:0]                fifo_count_s;
  logic                         fifo_empty_s, fifo_full_s;
  logic [PC_WIDTH+DATA_WIDTH-1:0] head_s;
  logic [CW-1:0]                occ_s, lim_s;
  logic                         unused_s;

  assign VALID_O = ~fifo_empty_s & ~REDIRECT_I & ~fault_s;
  assign pop_s   = VALID_O & READY_I;
  assign push_s  = ACK_I & outstanding_q & (state_q == ST_RUN) & ~REDIRECT_I;

  // Issue when in-flight plus buffered words, net of this cycle's pop, leave room.
  always_comb begin
    occ_s = fifo_count_s + CW'(outstanding_q);
    lim_s = CW'(FIFO_DEPTH) + CW'(pop_s);
    if ((state_q == ST_RUN) && !REDIRECT_I && !fault_s) begin
      issue_s = (occ_s < lim_s);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state: FSM, fetch PC and the PC tagged onto the pending request.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = issue_s;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN: begin
        if (REDIRECT_I && outstanding_q) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (REDIRECT_I) begin
      fetch_pc_d = {REDIRECT_PC_I[PC_WIDTH-1:2], 2'b00};
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      req_pc_d   = fetch_pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Fetch-control registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic                fault_q, fault_d;
  logic [PC_WIDTH-1:0] fault_pc_q, fault_pc_d;

  // A misaligned redirect latches the trap; any aligned redirect releases it.
  always_comb begin
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (REDIRECT_I) begin
      fault_d = is_misaligned(REDIRECT_PC_I[1:0]);
      if (is_misaligned(REDIRECT_PC_I[1:0])) begin
        fault_pc_d = REDIRECT_PC_I;
      end else begin
        fault_pc_d = fault_pc_q;
      end
    end else begin
      fault_d = fault_q;
    end
  end

  // Trap state registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign fault_s  = fault_q;
  assign FAULT_O  = fault_q;
  assign PC_O     = fault_q ? fault_pc_q : head_s[DATA_WIDTH +: PC_WIDTH];
  assign unused_s = fifo_full_s;
`else
  assign fault_s  = 1'b0;
  assign PC_O     = head_s[DATA_WIDTH +: PC_WIDTH];
  assign unused_s = ^{fifo_full_s, REDIRECT_PC_I[1:0]};
`endif

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PC_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .clear_i (REDIRECT_I),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  ({req_pc_q, DAT_I}),
    .data_o  (head_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

  assign INSTR_O = head_s[DATA_WIDTH-1:0];
  assign STB_O   = issue_s;
  assign WE_O    = 1'b0;
  assign ADR_O   = fetch_pc_q[ADDRESS_WIDTH+1:2];

endmodule

// File: tb/tb_ifetch_wishbone.sv
// Bench for ifetch_wishbone: ROM model, start-up/stall vector table, scoreboard of
// expected {PC, instr} pushed at each observed issue and popped at each handshake.
module tb_ifetch_wishbone;

  logic        clk = 1'b0;
  logic        RST_I = 1'b1;
  logic        STB_O, WE_O;
  logic [7:0]  ADR_O;
  logic [31:0] DAT_I = 32'd0;
  logic        ACK_I = 1'b0;
  logic        REDIRECT_I = 1'b0;
  logic [31:0] REDIRECT_PC_I = 32'd0;
  logic [31:0] INSTR_O, PC_O;
  logic        VALID_O;
  logic        READY_I = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        FAULT_O;
`endif

  always #5 clk = ~clk;

  ifetch_wishbone dut (
    .CLK_I         (clk),
    .RST_I         (RST_I),
    .STB_O         (STB_O),
    .WE_O          (WE_O),
    .ADR_O         (ADR_O),
    .DAT_I         (DAT_I),
    .ACK_I         (ACK_I),
    .REDIRECT_I    (REDIRECT_I),
    .REDIRECT_PC_I (REDIRECT_PC_I),
    .INSTR_O       (INSTR_O),
    .PC_O          (PC_O),
    .VALID_O       (VALID_O),
    .READY_I       (READY_I)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .FAULT_O       (FAULT_O)
`endif
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        chk_pc;
    logic        exp_stb;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t        vecs [22];
  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;
  int          hs = 0;
  int          hs0;
  logic [31:0] exp_issue_pc = 32'd0;
  logic        stb_prev = 1'b0;
  logic [7:0]  adr_prev = 8'd0;
  logic        s_stb, s_valid;
  logic [7:0]  s_adr;
  logic [31:0] s_pc, s_instr;
  logic        seen_400 = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {24'd0, pc[9:2]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdy, input logic chk_pc,
                              input logic stb, input logic vld,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.chk_pc = chk_pc; v.exp_stb = stb;
    v.exp_valid = vld; v.exp_pc = pc; v.exp_instr = ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs and ROM response at negedge, sample 1 ns later.
  task automatic cycle(input logic rst, input logic rdy, input logic redir,
                       input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    RST_I         = rst;
    READY_I       = rdy;
    REDIRECT_I    = redir;
    REDIRECT_PC_I = rpc;
    ACK_I         = stb_prev;
    DAT_I         = 32'h1000_0000 + {24'd0, adr_prev};
    #1;
    s_stb    = STB_O;
    s_valid  = VALID_O;
    s_adr    = ADR_O;
    s_pc     = PC_O;
    s_instr  = INSTR_O;
    stb_prev = STB_O;
    adr_prev = ADR_O;
    if (!rst && dut.push_s) begin
      chk("push_into_full", {31'd0, dut.fifo_full_s}, 32'd0);
    end
    if (rst) begin
      sb_q.delete();
      exp_issue_pc = 32'd0;
    end else if (redir) begin
      sb_q.delete();
      exp_issue_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (s_valid && rdy) begin
        hs++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %h, expected no output", s_pc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_pc", s_pc, e.pc);
          chk("sb_instr", s_instr, e.instr);
          if (e.pc == 32'h0000_0400 && s_instr == 32'h1000_0000) seen_400 = 1'b1;
        end
      end
      if (s_stb) begin
        chk("issue_adr", {24'd0, s_adr}, {24'd0, exp_issue_pc[9:2]});
        e.pc    = exp_issue_pc;
        e.instr = rom_word(exp_issue_pc);
        sb_q.push_back(e);
        exp_issue_pc = exp_issue_pc + 32'd4;
      end
    end
  endtask

  initial begin
    vecs[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    vecs[4] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    vecs[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1000_0000);
    vecs[6] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 32'h1000_0001);
    vecs[7] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h1000_0002);
    for (int i = 8; i < 18; i++) begin
      vecs[i] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC, 32'h1000_0003);
    end
    vecs[18] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  32'h1000_0003);
    vecs[19] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h1000_0004);
    vecs[20] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h1000_0005);
    vecs[21] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 32'h1000_0006);

    // Reset, start-up latency, 10-cycle stall and release.
    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].rst, vecs[i].rdy, 1'b0, 32'd0);
      if (i != 0) begin
        chk($sformatf("vec%0d_stb", i), {31'd0, s_stb}, {31'd0, vecs[i].exp_stb});
        chk($sformatf("vec%0d_valid", i), {31'd0, s_valid}, {31'd0, vecs[i].exp_valid});
        chk($sformatf("vec%0d_we", i), {31'd0, WE_O}, 32'd0);
      end
      if (vecs[i].chk_pc) begin
        chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), s_instr, vecs[i].exp_instr);
      end
    end

    // Redirect with a request outstanding, coinciding with ACK and a would-be pop.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("redir_valid", {31'd0, s_valid}, 32'd0);
    chk("redir_stb", {31'd0, s_stb}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flush_valid", {31'd0, s_valid}, 32'd0);
    chk("flush_stb", {31'd0, s_stb}, 32'd0);
    hs0 = hs;
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir40_progress", {31'd0, (hs - hs0) >= 6}, 32'd1);

    // Redirect with nothing outstanding: next cycle issues the new address.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("full_stall_stb", {31'd0, s_stb}, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("redir100_valid", {31'd0, s_valid}, 32'd0);
    chk("redir100_stb", {31'd0, s_stb}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir100_issue", {31'd0, s_stb}, 32'd1);
    chk("redir100_adr", {24'd0, s_adr}, 32'h0000_0040);
    hs0 = hs;
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir100_progress", {31'd0, (hs - hs0) >= 5}, 32'd1);

    // ROM address wrap across PC 0x400.
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_03F0);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_seen_400", {31'd0, seen_400}, 32'd1);

`ifdef IFETCH_MISALIGN_TRAP_EN
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0042);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("trap_fault", {31'd0, FAULT_O}, 32'd1);
      chk("trap_stb", {31'd0, s_stb}, 32'd0);
      chk("trap_valid", {31'd0, s_valid}, 32'd0);
      chk("trap_pc", s_pc, 32'h0000_0042);
    end
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0080);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("untrap_fault", {31'd0, FAULT_O}, 32'd0);
    chk("untrap_issue", {31'd0, s_stb}, 32'd1);
    hs0 = hs;
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("untrap_progress", {31'd0, (hs - hs0) >= 5}, 32'd1);
`else
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0042);
    hs0 = hs;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("misalign_progress", {31'd0, (hs - hs0) >= 5}, 32'd1);
`endif

    // Mid-stream reset: the ACK arriving right after reset must be dropped.
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rst_mid_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_mid_stb", {31'd0, s_stb}, 32'd0);
    hs0 = hs;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rst_mid_progress", {31'd0, (hs - hs0) >= 5}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
